// File: rtl/regfile_pkg.sv
// Shared definitions for the integer-pipeline register file: enable polarities,
// the zero word, bus types and register-count constants.
package regfile_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam int RegNum     = 32;
    localparam int RegNumLog2 = 5;

    typedef logic [31:0]           RegBus;
    typedef logic [RegNumLog2-1:0] RegAddrBus;

    localparam RegBus     ZeroWord   = 32'h0000_0000;
    localparam RegAddrBus NOPRegAddr = 5'b00000;

endpackage : regfile_pkg

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file. Priority: reset, read
// enable, register-0 alias, same-cycle write-through bypass, stored word.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              i_rst,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_stored,
    output logic [DATA_W-1:0] o_rdata
);

    // Select the read value; the zero checks come before the bypass so a
    // write aimed at register 0 can never leak onto a read of register 0.
    always_comb begin
        o_rdata = {DATA_W{1'b0}};
        if (i_rst == RstEnable) begin
            o_rdata = {DATA_W{1'b0}};
        end else if (i_re != ReadEnable) begin
            o_rdata = {DATA_W{1'b0}};
        end else if (i_raddr == {ADDR_W{1'b0}}) begin
            o_rdata = {DATA_W{1'b0}};
        end else if ((i_we == WriteEnable) && (i_raddr == i_waddr)) begin
            o_rdata = i_wdata;
        end else begin
            o_rdata = i_stored;
        end
    end

endmodule : regfile_rd_port

// File: rtl/regfile.sv
// General-purpose register file: 32 x 32-bit, register 0 hardwired to zero,
// one write port fed from WB and two combinational read ports for ID.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_stored1;
    logic [DATA_W-1:0] w_stored2;

    // Storage update: reset clears every word and swallows any concurrent
    // write; otherwise a write lands unless it targets register 0.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if ((we == WriteEnable) && (waddr != {ADDR_W{1'b0}})) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign w_stored1 = r_regs[raddr1];
    assign w_stored2 = r_regs[raddr2];

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port1 (
        .i_rst    (rst),
        .i_re     (re1),
        .i_raddr  (raddr1),
        .i_we     (we),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_stored (w_stored1),
        .o_rdata  (rdata1)
    );

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port2 (
        .i_rst    (rst),
        .i_re     (re2),
        .i_raddr  (raddr2),
        .i_we     (we),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_stored (w_stored2),
        .o_rdata  (rdata2)
    );

endmodule : regfile

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: an array model checked every cycle on the
// falling edge, plus hand-computed literal expectations for directed cases.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int vectors;
    int miscompares;

    logic [31:0] model [32];

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    // Clock generation, 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // What a read port must show, straight from the read rules.
    function automatic logic [31:0] model_read(input logic re, input logic [4:0] ra);
        if (rst || !re || ra == 5'd0) return 32'h0;
        if (we && ra == waddr) return wdata;
        return model[ra];
    endfunction

    // Model state update at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
    end

    // Per-cycle compare of both read ports against the model.
    always @(negedge clk) begin
        logic [31:0] e1;
        logic [31:0] e2;
        e1 = model_read(re1, raddr1);
        e2 = model_read(re2, raddr2);
        vectors++;
        if (rdata1 !== e1) begin
            miscompares++;
            $display("FAIL model_rdata1 t=%0t actual=%08h expected=%08h", $time, rdata1, e1);
        end
        vectors++;
        if (rdata2 !== e2) begin
            miscompares++;
            $display("FAIL model_rdata2 t=%0t actual=%08h expected=%08h", $time, rdata2, e2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset state
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);
        check("reset_rd1", rdata1, 32'h0);
        check("reset_rd2", rdata2, 32'h0);
        step(); step();

        // 1. Reset clears a preloaded register
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b1, 5'd5);
        check("t1_bypass_r5", rdata2, 32'hDEADBEEF);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        check("t1_preload_r5", rdata1, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        check("t1_reset_clears_r5", rdata1, 32'h0);
        step();

        // 2. Write then read, value persists
        drive(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7);
        check("t2_read_r7", rdata2, 32'h12345678);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t2_persist_r7", rdata2, 32'h12345678);
        end

        // 3. Register 0 is immutable and never bypassed
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        check("t3_r0_write_cycle_rd1", rdata1, 32'h0);
        check("t3_r0_write_cycle_rd2", rdata2, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);
        check("t3_r0_after", rdata1, 32'h0);
        step();

        // 4. Same-cycle bypass on both ports
        drive(1'b0, 1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
        check("t4_r3_old", rdata1, 32'h11111111);
        drive(1'b0, 1'b1, 5'd3, 32'h22222222, 1'b1, 5'd3, 1'b1, 5'd3);
        check("t4_bypass_rd1", rdata1, 32'h22222222);
        check("t4_bypass_rd2", rdata2, 32'h22222222);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
        check("t4_after_rd1", rdata1, 32'h22222222);
        check("t4_after_rd2", rdata2, 32'h22222222);
        step();

        // 5. Read enable gating
        drive(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b1, 5'd9);
        check("t5_gated_rd1", rdata1, 32'h0);
        check("t5_enabled_rd2", rdata2, 32'hA5A5A5A5);
        step();

        // Register 31, no address wrap
        drive(1'b0, 1'b1, 5'd31, 32'h31313131, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd0);
        check("r31_read", rdata1, 32'h31313131);
        check("r0_alias_rd2", rdata2, 32'h0);
        step();

        // Fill every register with a distinct pattern, then read pairs back
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101 ^ 32'h5A000000, 1'b1, 5'(i - 1), 1'b1, 5'(i));
            step();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
            step();
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 1'b1, 5'd1);
        check("fill_r16", rdata1, 32'h4A101010);
        check("fill_r1", rdata2, 32'h5B010101);
        step();

        // 6. Reset collides with a write
        drive(1'b1, 1'b1, 5'd4, 32'hCAFEF00D, 1'b1, 5'd4, 1'b1, 5'd4);
        check("t6_rst_rd1", rdata1, 32'h0);
        check("t6_rst_rd2", rdata2, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd16);
        check("t6_r4_lost", rdata1, 32'h0);
        check("t6_r16_cleared", rdata2, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_regfile
